pixel_stacker: RTL and testbench
================================

# pixel_stacker

Packs the camera pixel stream (one 16-bit RGB565 pixel per cycle, AXI-Stream style) into 128-bit phrases of eight pixels. It feeds the write-side AXIS FIFO that drives the DDR3 traffic generator's write port, so each output phrase maps to exactly one MIG write. It preserves frame-start markers so that the first phrase of every frame lands at DDR address 0, and it resynchronises cleanly when a frame start arrives mid-phrase.

## Interface
- PIXEL_W, 16: bits per pixel.
- PIXELS_PER_PHRASE, 8: pixels packed per phrase; must be a power of two, at least 2.
- PHRASE_W, PIXEL_W*PIXELS_PER_PHRASE: output width (128 by default).

- clk_in  in  1  single clock; the DDR3 UI clock domain side of the camera CDC FIFO.
- rst_in  in  1  synchronous, active-low reset (0 = reset).
- pixel_tdata  in  PIXEL_W  input pixel.
- pixel_tuser  in  1  first pixel of a frame.
- pixel_tvalid  in  1  input valid.
- pixel_tready  out  1  input ready.
- phrase_tdata  out  PHRASE_W  packed phrase.
- phrase_tuser  out  1  phrase contains the frame's first pixel.
- phrase_tvalid  out  1  output valid.
- phrase_tready  in  1  output ready.
- resync_count  out  16  saturating count of dropped partial phrases (stats build only).
- frame_count  out  16  wrapping count of emitted tuser phrases (stats build only).

## Operation
- Assembly register: pix_cnt (log2(PIXELS_PER_PHRASE) bits), shift buffer, first_tuser flag. Output register: phrase_tdata, phrase_tuser, phrase_tvalid.
- An accept occurs when pixel_tvalid && pixel_tready.
- Packing is LSB-first: pixel k of the phrase occupies bits [PIXEL_W*k +: PIXEL_W], so pixel 0 sits in [15:0].
- Accept with pix_cnt==0: store the pixel in slot 0 and set first_tuser=pixel_tuser.
- Accept with 0<pix_cnt, pixel_tuser=0: store the pixel in slot pix_cnt and increment pix_cnt.
- Accept with 0<pix_cnt, pixel_tuser=1 (resync):
  - Discard the partial phrase.
  - Store this pixel in slot 0, set pix_cnt=1 and first_tuser=1.
  - Increment resync_count, saturating at 0xFFFF.
- Accept at pix_cnt==PIXELS_PER_PHRASE-1 without resync:
  - Load the completed phrase into the output register: phrase_tuser=first_tuser, phrase_tvalid=1.
  - Wrap pix_cnt to 0.
  - Increment frame_count if first_tuser=1.
- Output states:
  - EMPTY (phrase_tvalid=0).
  - FULL (phrase_tvalid=1), which goes to EMPTY on phrase_tready unless a new phrase loads in the same cycle, in which case it stays FULL with the new data.
- pixel_tready = rst_in && !(pix_cnt==PIXELS_PER_PHRASE-1 && phrase_tvalid). It depends on registers only; there is no combinational path from phrase_tready.
- While phrase_tvalid=1 and phrase_tready=0, phrase_tdata and phrase_tuser are held stable.

## Timing
- Reset (rst_in=0 at a clk_in edge) clears:
  - pix_cnt=0, first_tuser=0, assembly buffer=0;
  - phrase_tvalid=0, phrase_tdata=0, phrase_tuser=0;
  - resync_count=0, frame_count=0.
- pixel_tready is 0 while rst_in=0.
- Reset asserted mid-phrase discards the partial phrase and any unconsumed output phrase. It does not count as a resync.
- Latency: when the last pixel of a phrase is accepted at edge N, phrase_tvalid=1 is visible after edge N. The phrase is consumed at the first edge where phrase_tready=1.
- Throughput: one pixel per cycle sustained as long as each phrase is consumed within PIXELS_PER_PHRASE-1 cycles of appearing.
- Stall: pixel_tready=0 only when the assembly buffer holds PIXELS_PER_PHRASE-1 pixels and the output is FULL. It returns to 1 the cycle after the output is consumed.
- A tuser pixel arriving while stalled is not accepted. It is processed on acceptance as a normal tuser pixel with pix_cnt==PIXELS_PER_PHRASE-1, which triggers a resync.

## Configuration
- STACKER_STATS_EN defined: resync_count and frame_count are implemented as specified above.
- STACKER_STATS_EN undefined: both outputs are tied to 0 and no counter logic is generated. Packing and resync behaviour are identical in both builds.

## Test plan
- Reset, then pixels 0x0001..0x0008 with tuser on the first and phrase_tready=1 -> one phrase 128'h0008_0007_0006_0005_0004_0003_0002_0001 with phrase_tuser=1, valid the cycle after the 8th accept; frame_count=1.
- phrase_tready=0, 16 pixels offered back-to-back -> first phrase held stable; pixel_tready drops after the 15th accept; raising phrase_tready gives phrase 2 one cycle after pixel 16 is accepted; no pixel lost.
- 3 pixels (tuser on the first), then a tuser pixel 0xAAAA plus 7 more -> the partial is dropped; the single emitted phrase has [15:0]=0xAAAA and phrase_tuser=1; resync_count=1.
- 5 pixels accepted, rst_in=0 for 1 cycle, then 8 pixels 0x0010..0x0017 -> exactly one phrase, [15:0]=0x0010, counters 0 after reset.
- 70000 forced resyncs -> resync_count saturates at 0xFFFF.
- Build without STACKER_STATS_EN, rerun the resync scenario -> identical phrases; resync_count=0, frame_count=0.

Source files
------------

// File: rtl/pixel_stacker.sv
// pixel_stacker: packs a 16-bit RGB565 pixel stream (AXI-Stream style) into
// PHRASE_W-bit phrases, LSB-first. A frame-start pixel (tuser) that arrives
// mid-phrase drops the partial phrase and restarts assembly at slot 0.
// Optional build macro: STACKER_STATS_EN enables resync_count / frame_count.
module pixel_stacker #(
  parameter int unsigned PIXEL_W           = 16,
  parameter int unsigned PIXELS_PER_PHRASE = 8,
  parameter int unsigned PHRASE_W          = PIXEL_W * PIXELS_PER_PHRASE
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [PIXEL_W-1:0]  pixel_tdata,
  input  logic                pixel_tuser,
  input  logic                pixel_tvalid,
  output logic                pixel_tready,
  output logic [PHRASE_W-1:0] phrase_tdata,
  output logic                phrase_tuser,
  output logic                phrase_tvalid,
  input  logic                phrase_tready,
  output logic [15:0]         resync_count,
  output logic [15:0]         frame_count
);

  localparam int unsigned CNT_W = $clog2(PIXELS_PER_PHRASE);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PIXELS_PER_PHRASE - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

  out_state_t           out_state;
  out_state_t           out_state_nxt;
  logic [CNT_W-1:0]     pix_cnt;
  logic [PHRASE_W-1:0]  asm_buf;
  logic                 first_tuser;

  logic accept_c;
  logic at_last_c;
  logic restart_c;
  logic resync_c;
  logic load_c;

  // Handshake and event decode shared by the assembly, output and stats logic.
  assign at_last_c    = (pix_cnt == LAST_IDX);
  assign pixel_tready = rst_in && !(at_last_c && phrase_tvalid);
  assign accept_c     = pixel_tvalid && pixel_tready;
  assign resync_c     = accept_c && pixel_tuser && (pix_cnt != '0);
  assign restart_c    = accept_c && ((pix_cnt == '0) || pixel_tuser);
  assign load_c       = accept_c && at_last_c && !pixel_tuser;
  assign phrase_tvalid = (out_state == FULL);

  // Assembly register: slot write, resync restart, wrap on completion.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      pix_cnt     <= '0;
      asm_buf     <= '0;
      first_tuser <= 1'b0;
    end else if (restart_c) begin
      asm_buf     <= PHRASE_W'(pixel_tdata);
      pix_cnt     <= CNT_W'(1);
      first_tuser <= pixel_tuser;
    end else if (load_c) begin
      pix_cnt <= '0;
    end else if (accept_c) begin
      for (int k = 1; k < int'(PIXELS_PER_PHRASE); k++) begin
        if (pix_cnt == CNT_W'(k)) begin
          asm_buf[k*PIXEL_W +: PIXEL_W] <= pixel_tdata;
        end
      end
      pix_cnt <= pix_cnt + CNT_W'(1);
    end
  end

  // Output payload register: loads the completed phrase, otherwise holds.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      phrase_tdata <= '0;
      phrase_tuser <= 1'b0;
    end else if (load_c) begin
      phrase_tdata <= {pixel_tdata, asm_buf[PHRASE_W-PIXEL_W-1:0]};
      phrase_tuser <= first_tuser;
    end
  end

  // Output state register.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      out_state <= EMPTY;
    end else begin
      out_state <= out_state_nxt;
    end
  end

  // Output next-state: a fresh load keeps FULL, otherwise drain on tready.
  always_comb begin
    out_state_nxt = out_state;
    case (out_state)
      EMPTY: if (load_c) out_state_nxt = FULL;
      FULL: begin
        if (load_c) begin
          out_state_nxt = FULL;
        end else if (phrase_tready) begin
          out_state_nxt = EMPTY;
        end
      end
      default: out_state_nxt = EMPTY;
    endcase
  end

`ifdef STACKER_STATS_EN
  logic [15:0] resync_q;
  logic [15:0] frame_q;

  // Statistics: saturating resync counter, wrapping frame-phrase counter.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      resync_q <= '0;
      frame_q  <= '0;
    end else begin
      if (resync_c && (resync_q != 16'hFFFF)) begin
        resync_q <= resync_q + 16'd1;
      end
      if (load_c && first_tuser) begin
        frame_q <= frame_q + 16'd1;
      end
    end
  end

  assign resync_count = resync_q;
  assign frame_count  = frame_q;
`else
  assign resync_count = 16'd0;
  assign frame_count  = 16'd0;
`endif

endmodule

// File: tb/tb_pixel_stacker.sv
// Directed bench for pixel_stacker with an expected-phrase scoreboard.
// Honours STACKER_STATS_EN for the counter expectations.
module tb_pixel_stacker;

`ifdef STACKER_STATS_EN
  localparam bit STATS = 1'b1;
  localparam int unsigned SAT_RUN = 65540;
`else
  localparam bit STATS = 1'b0;
  localparam int unsigned SAT_RUN = 20;
`endif

  logic         clk_in;
  logic         rst_in;
  logic [15:0]  pixel_tdata;
  logic         pixel_tuser;
  logic         pixel_tvalid;
  logic         pixel_tready;
  logic [127:0] phrase_tdata;
  logic         phrase_tuser;
  logic         phrase_tvalid;
  logic         phrase_tready;
  logic [15:0]  resync_count;
  logic [15:0]  frame_count;

  typedef struct packed {
    logic [127:0] data;
    logic         tuser;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  pixel_stacker dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .pixel_tdata   (pixel_tdata),
    .pixel_tuser   (pixel_tuser),
    .pixel_tvalid  (pixel_tvalid),
    .pixel_tready  (pixel_tready),
    .phrase_tdata  (phrase_tdata),
    .phrase_tuser  (phrase_tuser),
    .phrase_tvalid (phrase_tvalid),
    .phrase_tready (phrase_tready),
    .resync_count  (resync_count),
    .frame_count   (frame_count)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: scoreboard at the falling edge, then return just after the rising edge.
  task automatic cycle(output logic acc);
    exp_t e;
    @(negedge clk_in);
    if (rst_in && phrase_tvalid && phrase_tready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_phrase", 128'(phrase_tvalid), 128'd0);
      end else begin
        e = exp_q.pop_front();
        check("phrase_tdata", phrase_tdata, e.data);
        check("phrase_tuser", 128'(phrase_tuser), 128'(e.tuser));
      end
    end
    acc = rst_in && pixel_tvalid && pixel_tready;
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int n);
    logic acc;
    pixel_tvalid = 1'b0;
    for (int i = 0; i < n; i++) cycle(acc);
  endtask

  task automatic drive(input logic [15:0] d, input logic u);
    pixel_tdata  = d;
    pixel_tuser  = u;
    pixel_tvalid = 1'b1;
  endtask

  // Waits for the offered pixel to be accepted; returns cycles spent.
  task automatic wait_accept(output int n);
    logic acc;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 100) begin
      cycle(acc);
      n++;
    end
    if (!acc) check("accept_timeout", 128'(acc), 128'd1);
    pixel_tvalid = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, input logic u);
    int n;
    drive(d, u);
    wait_accept(n);
  endtask

  // Sends first (with tuser u) then n_rest consecutive pixels starting at base.
  task automatic send_run(input logic [15:0] first, input logic u,
                          input logic [15:0] base, input int n_rest);
    send(first, u);
    for (int i = 0; i < n_rest; i++) send(base + 16'(i), 1'b0);
  endtask

  function automatic logic [127:0] seq_phrase(input logic [15:0] first, input logic [15:0] base);
    logic [127:0] p;
    p = '0;
    p[15:0] = first;
    for (int k = 1; k < 8; k++) p[16*k +: 16] = base + 16'(k - 1);
    return p;
  endfunction

  task automatic expect_phrase(input logic [127:0] d, input logic u);
    exp_t e;
    e.data  = d;
    e.tuser = u;
    exp_q.push_back(e);
  endtask

  initial begin
    int n;
    logic acc;
    rst_in        = 1'b0;
    pixel_tdata   = '0;
    pixel_tuser   = 1'b0;
    pixel_tvalid  = 1'b0;
    phrase_tready = 1'b0;
    @(posedge clk_in);
    #1;
    idle(2);

    // Reset state.
    check("rst_pixel_tready", 128'(pixel_tready), 128'd0);
    check("rst_phrase_tvalid", 128'(phrase_tvalid), 128'd0);
    check("rst_phrase_tdata", phrase_tdata, 128'd0);
    check("rst_counters", 128'({resync_count, frame_count}), 128'd0);
    rst_in = 1'b1;
    #1;
    check("post_rst_tready", 128'(pixel_tready), 128'd1);

    // Basic phrase with frame start.
    phrase_tready = 1'b1;
    expect_phrase(128'h0008_0007_0006_0005_0004_0003_0002_0001, 1'b1);
    send_run(16'h0001, 1'b1, 16'h0002, 6);
    check("t1_not_yet_valid", 128'(phrase_tvalid), 128'd0);
    send(16'h0008, 1'b0);
    check("t1_valid_latency", 128'(phrase_tvalid), 128'd1);
    check("t1_frame_count", 128'(frame_count), STATS ? 128'd1 : 128'd0);
    idle(3);
    check("t1_drained", 128'(exp_q.size()), 128'd0);

    // Back-pressure: first phrase held, stall after 15 accepts.
    phrase_tready = 1'b0;
    expect_phrase(seq_phrase(16'h0101, 16'h0102), 1'b0);
    expect_phrase(seq_phrase(16'h0109, 16'h010A), 1'b0);
    send_run(16'h0101, 1'b0, 16'h0102, 14);
    check("t2_stall_tready", 128'(pixel_tready), 128'd0);
    check("t2_held_valid", 128'(phrase_tvalid), 128'd1);
    drive(16'h0110, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(acc);
      check("t2_no_accept_stalled", 128'(acc), 128'd0);
    end
    check("t2_held_tdata", phrase_tdata, seq_phrase(16'h0101, 16'h0102));
    check("t2_held_tuser", 128'(phrase_tuser), 128'd0);
    phrase_tready = 1'b1;
    wait_accept(n);
    check("t2_resume_cycles", 128'(n), 128'd2);
    check("t2_phrase2_valid", 128'(phrase_tvalid), 128'd1);
    idle(3);
    check("t2_drained", 128'(exp_q.size()), 128'd0);

    // Resync: partial of 3 dropped, restart at 0xAAAA.
    expect_phrase(seq_phrase(16'hAAAA, 16'h0A01), 1'b1);
    send_run(16'h0201, 1'b1, 16'h0202, 2);
    send_run(16'hAAAA, 1'b1, 16'h0A01, 7);
    idle(3);
    check("t3_drained", 128'(exp_q.size()), 128'd0);
    check("t3_resync_count", 128'(resync_count), STATS ? 128'd1 : 128'd0);
    check("t3_frame_count", 128'(frame_count), STATS ? 128'd2 : 128'd0);

    // Mid-phrase reset discards the partial and clears counters.
    send_run(16'h0301, 1'b1, 16'h0302, 4);
    rst_in = 1'b0;
    idle(1);
    check("t4_rst_counters", 128'({resync_count, frame_count}), 128'd0);
    check("t4_rst_valid", 128'(phrase_tvalid), 128'd0);
    rst_in = 1'b1;
    expect_phrase(seq_phrase(16'h0010, 16'h0011), 1'b1);
    send_run(16'h0010, 1'b1, 16'h0011, 7);
    idle(3);
    check("t4_drained", 128'(exp_q.size()), 128'd0);
    check("t4_resync_zero", 128'(resync_count), 128'd0);
    check("t4_frame_count", 128'(frame_count), STATS ? 128'd1 : 128'd0);

    // Back-to-back tuser pixels force a resync on every accept.
    send(16'hBEEF, 1'b1);
    drive(16'hBEEF, 1'b1);
    for (int i = 0; i < int'(SAT_RUN); i++) cycle(acc);
    pixel_tvalid = 1'b0;
    check("t5_resync_count", 128'(resync_count), STATS ? 128'hFFFF : 128'd0);
    expect_phrase(seq_phrase(16'hBEEF, 16'h0C01), 1'b1);
    for (int i = 0; i < 7; i++) send(16'h0C01 + 16'(i), 1'b0);
    idle(3);
    check("t5_drained", 128'(exp_q.size()), 128'd0);
    check("t5_frame_count", 128'(frame_count), STATS ? 128'd2 : 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
